// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 SCCB responder: FSM states, register map
// and reset defaults.
package ov7670_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDAT,
        ST_WDAT_ACK,
        ST_RDAT,
        ST_RD_NA,
        ST_IGNORE
    } sccb_state_t;

    localparam logic [7:0] DEF_DEV_ID  = 8'h42;
    localparam logic [7:0] REG_PID     = 8'h0A;
    localparam logic [7:0] REG_VER     = 8'h0B;
    localparam logic [7:0] PID_DEFAULT = 8'h76;
    localparam logic [7:0] VER_DEFAULT = 8'h73;

    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        if (addr == REG_PID) return PID_DEFAULT;
        if (addr == REG_VER) return VER_DEFAULT;
        return 8'h00;
    endfunction

    function automatic logic is_read_only(input logic [7:0] addr);
        return (addr == REG_PID) || (addr == REG_VER);
    endfunction

endpackage

// File: rtl/sccb_line_filter.sv
// Synchroniser, consecutive-sample glitch filter and registered edge detect
// for one SCCB line. Lines idle high, so everything resets to 1.
module sccb_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt     <= '0;
            level   <= 1'b1;
            level_d <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], line};
            level_d <= level;
            // level only follows after FILT_CYCLES consecutive differing samples
            if (sync_q[SYNC_STAGES-1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_CYCLES - 1)) begin
                level <= sync_q[SYNC_STAGES-1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target modelling the OV7670 register interface: 3-phase writes and
// 2-phase write + 2-phase read against a 256x8 register file.
module sccb_responder
    import ov7670_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = DEF_DEV_ID,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_CYCLES = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       cam_sioc,
    inout  wire        cam_siod,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic [7:0] i_dbg_addr,
    output logic [7:0] o_dbg_data,
    output logic       o_busy
);

    logic sioc_lvl, sioc_rise, sioc_fall;
    logic siod_lvl, siod_rise, siod_fall;

    sccb_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sioc_filt (
        .clk(i_clk), .rst_n(i_rst_n), .line(cam_sioc),
        .level(sioc_lvl), .rise(sioc_rise), .fall(sioc_fall)
    );

    sccb_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_siod_filt (
        .clk(i_clk), .rst_n(i_rst_n), .line(cam_siod),
        .level(siod_lvl), .rise(siod_rise), .fall(siod_fall)
    );

    sccb_state_t state;
    logic [7:0]  regs [256];
    logic [7:0]  shreg;
    logic [7:0]  ptr;
    logic [2:0]  bit_cnt;
    logic        rd;
    logic        siod_oe;
    logic [7:0]  byte_in;
    logic        start_ev, stop_ev;

    assign start_ev   = siod_fall & sioc_lvl;
    assign stop_ev    = siod_rise & sioc_lvl;
    assign byte_in    = {shreg[6:0], siod_lvl};
    assign cam_siod   = siod_oe ? 1'b0 : 1'bz;
    assign o_dbg_data = regs[i_dbg_addr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            ptr        <= '0;
            bit_cnt    <= '0;
            rd         <= 1'b0;
            siod_oe    <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i));
        end else begin
            o_wr_valid <= 1'b0;
            if (stop_ev) begin
                state   <= ST_IDLE;
                siod_oe <= 1'b0;
                o_busy  <= 1'b0;
            end else if (start_ev) begin
                state   <= ST_ID;
                siod_oe <= 1'b0;
                bit_cnt <= '0;
                o_busy  <= 1'b1;
            end else begin
                case (state)
                    ST_ID, ST_SUB, ST_WDAT: begin
                        if (sioc_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    ST_ID: begin
                                        if (byte_in == DEV_ID) begin
                                            rd    <= 1'b0;
                                            state <= ST_ID_ACK;
                                        end else if (byte_in == (DEV_ID | 8'h01)) begin
                                            rd    <= 1'b1;
                                            state <= ST_ID_ACK;
                                        end else begin
                                            state <= ST_IGNORE;
                                        end
                                    end
                                    ST_SUB: begin
                                        ptr   <= byte_in;
                                        state <= ST_SUB_ACK;
                                    end
                                    default: begin
                                        if (!is_read_only(ptr)) begin
                                            regs[ptr]  <= byte_in;
                                            o_wr_valid <= 1'b1;
                                            o_wr_addr  <= ptr;
                                            o_wr_data  <= byte_in;
                                        end
                                        state <= ST_WDAT_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // first falling edge drives the ack, the second releases it
                    ST_ID_ACK, ST_SUB_ACK, ST_WDAT_ACK: begin
                        if (sioc_fall) begin
                            if (!siod_oe) begin
                                siod_oe <= 1'b1;
                            end else begin
                                siod_oe <= 1'b0;
                                case (state)
                                    ST_ID_ACK: begin
                                        if (rd) begin
                                            state   <= ST_RDAT;
                                            shreg   <= {regs[ptr][6:0], 1'b0};
                                            siod_oe <= ~regs[ptr][7];
                                            bit_cnt <= '0;
                                        end else begin
                                            state <= ST_SUB;
                                        end
                                    end
                                    ST_SUB_ACK: state <= ST_WDAT;
                                    default:    state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_RDAT: begin
                        if (sioc_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                siod_oe <= 1'b0;
                                state   <= ST_RD_NA;
                            end else begin
                                siod_oe <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_NA: begin
                        if (sioc_rise) state <= ST_IGNORE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: an SCCB master model plus table-driven
// register checks through the debug port.
module tb_sccb_responder;

    localparam int Q = 8;  // clocks per quarter SIOC period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sioc = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] dbg_addr = 8'h00;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data, dbg_data;
    logic       busy;
    wire        siod;

    pullup (siod);
    assign siod = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .cam_sioc   (sioc),
        .cam_siod   (siod),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
        .o_busy     (busy)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;
    int         drive_cnt = 0;
    int         busy_low_cnt = 0;
    logic       watch_busy = 1'b0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (!m_low && siod == 1'b0) drive_cnt++;
        if (watch_busy && !busy) busy_low_cnt++;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } dbg_vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_table(input string name, input dbg_vec_t tbl[$]);
        foreach (tbl[i]) begin
            dbg_addr = tbl[i].addr;
            #1;
            chk($sformatf("%s[%02h]", name, tbl[i].addr), dbg_data, tbl[i].exp);
        end
    endtask

    task automatic wq(input int n = 1);
        repeat (n * Q) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        if (!sioc) begin
            wq(); m_low = 1'b0; wq(); sioc = 1'b1; wq();
        end
        m_low = 1'b1; wq(2); sioc = 1'b0; wq();
    endtask

    task automatic m_stop();
        m_low = 1'b1; wq(); sioc = 1'b1; wq(2); m_low = 1'b0; wq(2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit glitch);
        for (int i = 7; i > 7 - n; i--) begin
            m_low = ~b[i];
            if (glitch) begin
                repeat (3) @(posedge clk);
                #1 sioc = 1'b1;
                @(posedge clk);
                #1 sioc = 1'b0;
            end
            wq(); sioc = 1'b1; wq(2); sioc = 1'b0; wq();
        end
    endtask

    task automatic get_ack(output logic a);
        m_low = 1'b0; wq(); sioc = 1'b1; wq(); a = siod; wq(); sioc = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch, output logic a);
        send_bits(b, 8, glitch);
        get_ack(a);
    endtask

    task automatic read_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        m_low = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            wq(); sioc = 1'b1; wq(); b[i] = siod; wq(); sioc = 1'b0; wq();
        end
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na);
        read_bits(8, b);
        wq(); sioc = 1'b1; wq(); na = siod; wq(); sioc = 1'b0; wq();
    endtask

    // Set the pointer with a 2-phase write, then read it back with a repeated START.
    task automatic ptr_read(input logic [7:0] sub, output logic [7:0] b, output logic na);
        logic a;
        m_start();
        write_byte(8'h42, 1'b0, a); chk("pr_ack_id", {7'd0, a}, 8'h00);
        write_byte(sub, 1'b0, a);   chk("pr_ack_sub", {7'd0, a}, 8'h00);
        m_start();
        write_byte(8'h43, 1'b0, a); chk("pr_ack_rid", {7'd0, a}, 8'h00);
        read_byte(b, na);
        m_stop();
    endtask

    initial begin
        dbg_vec_t   rst_tbl[$];
        dbg_vec_t   end_tbl[$];
        logic       a0, a1, a2, na;
        logic [7:0] rb;
        int         w0, d0, b0;

        rst_tbl = '{'{8'h0A, 8'h76}, '{8'h0B, 8'h73}, '{8'h00, 8'h00},
                    '{8'h12, 8'h00}, '{8'h30, 8'h00}, '{8'hFF, 8'h00}};
        end_tbl = '{'{8'h12, 8'h80}, '{8'h0A, 8'h76}, '{8'h0B, 8'h73},
                    '{8'h20, 8'h00}, '{8'h30, 8'hAA}, '{8'h13, 8'h5A}};

        // reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_wr_valid", {7'd0, wr_valid}, 8'h00);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_siod", {7'd0, siod}, 8'h01);
        chk_table("rst_reg", rst_tbl);
        rst_n = 1'b1;
        wq(2);

        // 3-phase write 42/12/80
        w0 = wr_cnt;
        m_start();
        write_byte(8'h42, 1'b0, a0);
        write_byte(8'h12, 1'b0, a1);
        write_byte(8'h80, 1'b0, a2);
        chk("wr_ack_id", {7'd0, a0}, 8'h00);
        chk("wr_ack_sub", {7'd0, a1}, 8'h00);
        chk("wr_ack_dat", {7'd0, a2}, 8'h00);
        chk("wr_busy_mid", {7'd0, busy}, 8'h01);
        m_stop();
        chk("wr_busy_end", {7'd0, busy}, 8'h00);
        chk("wr_pulses", 8'(wr_cnt - w0), 8'h01);
        chk("wr_addr", last_addr, 8'h12);
        chk("wr_data", last_data, 8'h80);
        dbg_addr = 8'h12; #1;
        chk("wr_reg12", dbg_data, 8'h80);

        // read PID and VER
        ptr_read(8'h0A, rb, na);
        chk("rd_pid", rb, 8'h76);
        chk("rd_pid_na_rel", {7'd0, na}, 8'h01);
        ptr_read(8'h0B, rb, na);
        chk("rd_ver", rb, 8'h73);

        // foreign device ID: never driven, nothing written
        w0 = wr_cnt; d0 = drive_cnt;
        m_start();
        write_byte(8'h60, 1'b0, a0);
        write_byte(8'h12, 1'b0, a1);
        write_byte(8'h34, 1'b0, a2);
        write_byte(8'h56, 1'b0, a2);
        m_stop();
        chk("id_mis_ack", {7'd0, a0}, 8'h01);
        chk("id_mis_drive", 8'(drive_cnt - d0), 8'h00);
        chk("id_mis_pulses", 8'(wr_cnt - w0), 8'h00);
        dbg_addr = 8'h12; #1;
        chk("id_mis_reg12", dbg_data, 8'h80);

        // STOP mid data byte: discarded, pointer kept at 20
        w0 = wr_cnt;
        m_start();
        write_byte(8'h42, 1'b0, a0);
        write_byte(8'h20, 1'b0, a1);
        send_bits(8'h55, 4, 1'b0);
        m_stop();
        chk("part_pulses", 8'(wr_cnt - w0), 8'h00);
        m_start();
        write_byte(8'h43, 1'b0, a0);
        read_byte(rb, na);
        m_stop();
        chk("part_rd_ptr", rb, 8'h00);

        // repeated START mid sub-address
        w0 = wr_cnt;
        m_start();
        write_byte(8'h42, 1'b0, a0);
        send_bits(8'h77, 4, 1'b0);
        b0 = busy_low_cnt;
        watch_busy = 1'b1;
        m_start();
        write_byte(8'h42, 1'b0, a0);
        write_byte(8'h30, 1'b0, a1);
        write_byte(8'hAA, 1'b0, a2);
        watch_busy = 1'b0;
        m_stop();
        chk("rs_busy_low", 8'(busy_low_cnt - b0), 8'h00);
        chk("rs_pulses", 8'(wr_cnt - w0), 8'h01);
        chk("rs_addr", last_addr, 8'h30);
        chk("rs_data", last_data, 8'hAA);

        // write to read-only PID
        w0 = wr_cnt;
        m_start();
        write_byte(8'h42, 1'b0, a0);
        write_byte(8'h0A, 1'b0, a1);
        write_byte(8'hFF, 1'b0, a2);
        m_stop();
        chk("ro_ack_dat", {7'd0, a2}, 8'h00);
        chk("ro_pulses", 8'(wr_cnt - w0), 8'h00);

        // 1-cycle SIOC glitches inside every data bit
        w0 = wr_cnt;
        m_start();
        write_byte(8'h42, 1'b0, a0);
        write_byte(8'h13, 1'b0, a1);
        write_byte(8'h5A, 1'b1, a2);
        m_stop();
        chk("gl_ack_dat", {7'd0, a2}, 8'h00);
        chk("gl_pulses", 8'(wr_cnt - w0), 8'h01);
        chk("gl_data", last_data, 8'h5A);

        chk_table("end_reg", end_tbl);

        // async reset while driving read bit 0 of 0x80
        m_start();
        write_byte(8'h42, 1'b0, a0);
        write_byte(8'h12, 1'b0, a1);
        m_start();
        write_byte(8'h43, 1'b0, a0);
        read_bits(7, rb);
        chk("ar_bits", rb, 8'h80);
        chk("ar_bit0_drv", {7'd0, siod}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_siod_rel", {7'd0, siod}, 8'h01);
        chk("ar_busy", {7'd0, busy}, 8'h00);
        chk("ar_wr_addr", wr_addr, 8'h00);
        chk_table("ar_reg", rst_tbl);
        wq(1);
        rst_n = 1'b1;
        wq(1);
        m_stop();
        chk("ar_busy_after", {7'd0, busy}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
